multicycle_ctrl_fsm: RTL and testbench

- Multicycle successor to the single-cycle main decoder. Sequences each MIPS instruction through fetch/decode/execute/memory/writeback states.
- Drives datapath enables and muxes one state per cycle.
- Adds a memory-ready stall handshake and illegal-opcode trapping.
- Sits between the instruction register opcode field and the multicycle datapath; `aludec` is reused unchanged on `aluop`.

---
 rtl/mips_ctrl_pkg.sv | 45 ++++
 rtl/multicycle_ctrl_fsm.sv | 159 +++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALU
// operation classes, FSM state encodings and datapath mux selects.
package mips_ctrl_pkg;

   // Opcode field values recognised by the controller
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALU operation class handed to aludec
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU B operand select
   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Controller states; encodings 12..15 are unused and recover to FETCH
   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
   } state_t;

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS main controller. Sequences each instruction through
// fetch/decode/execute/memory/writeback, holding memory states until the
// unified memory reports ready, and trapping unknown opcodes in DECODE.
module multicycle_ctrl_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W     = 6,
   parameter int ALUOP_W  = 2,
   parameter int STATE_W  = 4,
   parameter bit MEM_WAIT = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [OP_W-1:0]    op,
   input  logic               mem_ready,
   output logic               pcwrite,
   output logic               branch,
   output logic               iord,
   output logic               memwrite,
   output logic               irwrite,
   output logic               regwrite,
   output logic               regdst,
   output logic               memtoreg,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [ALUOP_W-1:0] aluop,
   output logic               illegal,
   output logic [STATE_W-1:0] state_o
);

   state_t state;
   state_t state_nx;
   logic   ready;
   logic   op_known;

   // Without the wait option every memory access is assumed to finish in one cycle
   assign ready = MEM_WAIT ? mem_ready : 1'b1;

   // Opcodes that DECODE can dispatch; anything else is trapped
   assign op_known = (op == OP_W'(OP_LW))   || (op == OP_W'(OP_SW))   ||
                     (op == OP_W'(OP_RTYPE)) || (op == OP_W'(OP_BEQ))  ||
                     (op == OP_W'(OP_ADDI))  || (op == OP_W'(OP_J));

   assign state_o = STATE_W'(state);

   // State register; reset takes priority over any pending transition
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of block ordering.
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state selection
   always_comb begin
      // NOTE: default first so every path assigns state_nx and no latch forms.
      state_nx = S_FETCH;
      case (state)
         S_FETCH:   state_nx = ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if ((op == OP_W'(OP_LW)) || (op == OP_W'(OP_SW))) begin
               state_nx = S_MEMADR;
            end else if (op == OP_W'(OP_RTYPE)) begin
               state_nx = S_RTYPEEX;
            end else if (op == OP_W'(OP_BEQ)) begin
               state_nx = S_BEQEX;
            end else if (op == OP_W'(OP_ADDI)) begin
               state_nx = S_ADDIEX;
            end else if (op == OP_W'(OP_J)) begin
               state_nx = S_JEX;
            end else begin
               state_nx = S_FETCH;
            end
         end
         S_MEMADR:  state_nx = (op == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_nx = ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:   state_nx = ready ? S_FETCH : S_MEMWR;
         S_RTYPEEX: state_nx = S_RTYPEWB;
         S_ADDIEX:  state_nx = S_ADDIWB;
         S_MEMWB, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX: state_nx = S_FETCH;
         default:   state_nx = S_FETCH;
      endcase
   end

   // Datapath control decode from the registered state
   always_comb begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      iord     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = SRCB_RT;
      pcsrc    = PCSRC_ALU;
      aluop    = ALUOP_W'(ALUOP_ADD);
      illegal  = 1'b0;
      case (state)
         S_FETCH: begin
            alusrcb = SRCB_FOUR;
            irwrite = ready;
            pcwrite = ready;
         end
         S_DECODE: begin
            alusrcb = SRCB_IMM_SH2;
            illegal = ~op_known;
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         S_MEMRD: begin
            iord = 1'b1;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_W'(ALUOP_FUNCT);
         end
         S_RTYPEWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         S_BEQEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_W'(ALUOP_SUB);
            branch  = 1'b1;
            pcsrc   = PCSRC_ALUOUT;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         S_ADDIWB: begin
            regwrite = 1'b1;
         end
         S_JEX: begin
            pcsrc   = PCSRC_JUMP;
            pcwrite = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Each cycle's expected output
// vector is queued when the stimulus is driven and checked on the falling
// edge; scenario tasks add their own checks on latency and strobe counts.
module tb_multicycle_ctrl_fsm;

   localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3;
   localparam logic [3:0] MEMWB = 4'd4, MEMWR = 4'd5, RTYPEEX = 4'd6, RTYPEWB = 4'd7;
   localparam logic [3:0] BEQEX = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JEX = 4'd11;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

   typedef struct packed {
      logic [3:0] state;
      logic       pcwrite, branch, iord, memwrite, irwrite;
      logic       regwrite, regdst, memtoreg, alusrca;
      logic [1:0] alusrcb, pcsrc, aluop;
      logic       illegal;
   } obs_t;

   typedef struct {
      int    which;
      string name;
      obs_t  e;
   } sb_t;

   logic clk = 1'b0;
   logic rst, rst2, mem_ready;
   logic [5:0] op, op2;

   logic [3:0] st_a, st_b;
   logic pcw_a, br_a, iord_a, mw_a, irw_a, rw_a, rd_a, m2r_a, sa_a, ill_a;
   logic pcw_b, br_b, iord_b, mw_b, irw_b, rw_b, rd_b, m2r_b, sa_b, ill_b;
   logic [1:0] sb_a, pcs_a, aop_a, sb_b, pcs_b, aop_b;
   obs_t obs1, obs2;

   int tests = 0;
   int fails = 0;
   sb_t sb[$];

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(.OP_W(6), .ALUOP_W(2), .STATE_W(4), .MEM_WAIT(1'b1)) dut (
      .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
      .pcwrite(pcw_a), .branch(br_a), .iord(iord_a), .memwrite(mw_a), .irwrite(irw_a),
      .regwrite(rw_a), .regdst(rd_a), .memtoreg(m2r_a), .alusrca(sa_a), .alusrcb(sb_a),
      .pcsrc(pcs_a), .aluop(aop_a), .illegal(ill_a), .state_o(st_a)
   );

   multicycle_ctrl_fsm #(.OP_W(6), .ALUOP_W(2), .STATE_W(4), .MEM_WAIT(1'b0)) dut_nowait (
      .clk(clk), .rst(rst2), .op(op2), .mem_ready(1'b0),
      .pcwrite(pcw_b), .branch(br_b), .iord(iord_b), .memwrite(mw_b), .irwrite(irw_b),
      .regwrite(rw_b), .regdst(rd_b), .memtoreg(m2r_b), .alusrca(sa_b), .alusrcb(sb_b),
      .pcsrc(pcs_b), .aluop(aop_b), .illegal(ill_b), .state_o(st_b)
   );

   assign obs1 = {st_a, pcw_a, br_a, iord_a, mw_a, irw_a, rw_a, rd_a, m2r_a, sa_a,
                  sb_a, pcs_a, aop_a, ill_a};
   assign obs2 = {st_b, pcw_b, br_b, iord_b, mw_b, irw_b, rw_b, rd_b, m2r_b, sa_b,
                  sb_b, pcs_b, aop_b, ill_b};

   // Expected Moore outputs for a state, derived from the control table
   function automatic obs_t mk(input logic [3:0] s, input logic rdy, input logic ill);
      obs_t e;
      e = '0;
      e.state = s;
      case (s)
         FETCH:   begin e.alusrcb = 2'b01; e.irwrite = rdy; e.pcwrite = rdy; end
         DECODE:  begin e.alusrcb = 2'b11; e.illegal = ill; end
         MEMADR:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
         MEMRD:   begin e.iord = 1'b1; end
         MEMWR:   begin e.iord = 1'b1; e.memwrite = 1'b1; end
         MEMWB:   begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
         RTYPEEX: begin e.alusrca = 1'b1; e.aluop = 2'b10; end
         RTYPEWB: begin e.regdst = 1'b1; e.regwrite = 1'b1; end
         BEQEX:   begin e.alusrca = 1'b1; e.aluop = 2'b01; e.branch = 1'b1; e.pcsrc = 2'b01; end
         ADDIEX:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
         ADDIWB:  begin e.regwrite = 1'b1; end
         JEX:     begin e.pcsrc = 2'b10; e.pcwrite = 1'b1; end
         default: begin end
      endcase
      return e;
   endfunction

   // Scoreboard: pop the expectation queued for this cycle and compare
   always @(negedge clk) begin
      sb_t  it;
      obs_t got;
      if (sb.size() > 0) begin
         it  = sb.pop_front();
         got = (it.which == 0) ? obs1 : obs2;
         tests++;
         if (got !== it.e) begin
            fails++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                     it.name, got, got.state, it.e, it.e.state);
         end
      end
   end

   // Drive one cycle's inputs, queue its expectation, return the sampled outputs
   task automatic cyc(input int which, input logic [5:0] o, input logic r,
                      input obs_t e, input string nm, output obs_t got);
      sb_t it;
      if (which == 0) begin
         op = o;
         mem_ready = r;
      end else begin
         op2 = o;
      end
      it.which = which;
      it.name  = nm;
      it.e     = e;
      sb.push_back(it);
      @(negedge clk);
      got = (which == 0) ? obs1 : obs2;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t g;
      cyc(0, RT, 1'b0, mk(FETCH, 1'b0, 1'b0), "reset_fetch", g);
      rst = 1'b0;
      cyc(0, RT, 1'b0, mk(FETCH, 1'b0, 1'b0), "fetch_not_ready", g);
      tests++;
      if (st_a !== FETCH) begin
         fails++;
         $display("FAIL fetch_hold: state %0d expected %0d", st_a, FETCH);
      end
   endtask

   task automatic test_lw();
      logic [3:0] seq [5] = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
      obs_t g;
      int regw = 0;
      int rw_idx = -1;
      for (int i = 0; i < 5; i++) begin
         cyc(0, LW, 1'b1, mk(seq[i], 1'b1, 1'b0), $sformatf("lw_c%0d", i), g);
         if (g.regwrite && g.memtoreg) begin
            regw++;
            rw_idx = i;
         end
      end
      tests++;
      if (regw != 1 || rw_idx != 4) begin
         fails++;
         $display("FAIL lw_writeback: %0d cycles at index %0d expected 1 at 4", regw, rw_idx);
      end
      tests++;
      if (st_a !== FETCH) begin
         fails++;
         $display("FAIL lw_latency: state %0d after 5 cycles expected %0d", st_a, FETCH);
      end
   endtask

   task automatic test_sw_stall();
      logic [3:0] seq [7] = '{FETCH, DECODE, MEMADR, MEMWR, MEMWR, MEMWR, MEMWR};
      logic       rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      obs_t g;
      int mw = 0;
      int first = -1;
      int last = -1;
      int regw = 0;
      for (int i = 0; i < 7; i++) begin
         cyc(0, SW, rdy[i], mk(seq[i], rdy[i], 1'b0), $sformatf("sw_c%0d", i), g);
         if (g.memwrite) begin
            mw++;
            if (first < 0) first = i;
            last = i;
         end
         if (g.regwrite) regw++;
      end
      tests++;
      if (mw != 4 || (last - first) != 3) begin
         fails++;
         $display("FAIL sw_memwrite: %0d cycles span %0d..%0d expected 4 consecutive", mw, first, last);
      end
      tests++;
      if (regw != 0) begin
         fails++;
         $display("FAIL sw_no_regwrite: %0d regwrite cycles expected 0", regw);
      end
      tests++;
      if (st_a !== FETCH) begin
         fails++;
         $display("FAIL sw_return: state %0d expected %0d", st_a, FETCH);
      end
   endtask

   task automatic test_reset_mid_stall();
      obs_t g;
      cyc(0, LW, 1'b1, mk(FETCH, 1'b1, 1'b0), "rst_fetch", g);
      cyc(0, LW, 1'b1, mk(DECODE, 1'b1, 1'b0), "rst_decode", g);
      cyc(0, LW, 1'b1, mk(MEMADR, 1'b1, 1'b0), "rst_memadr", g);
      cyc(0, LW, 1'b0, mk(MEMRD, 1'b0, 1'b0), "rst_memrd_stall", g);
      rst = 1'b1;
      cyc(0, LW, 1'b0, mk(MEMRD, 1'b0, 1'b0), "rst_memrd_no_comb_rst", g);
      cyc(0, LW, 1'b0, mk(FETCH, 1'b0, 1'b0), "rst_to_fetch", g);
      tests++;
      if (g.state !== FETCH || g.pcwrite !== 1'b0 || g.irwrite !== 1'b0 || g.alusrcb !== 2'b01) begin
         fails++;
         $display("FAIL rst_mid_stall: state %0d pcw %b irw %b srcb %b expected 0 0 0 01",
                  g.state, g.pcwrite, g.irwrite, g.alusrcb);
      end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [3:0] seq [14] = '{FETCH, DECODE, RTYPEEX, RTYPEWB,
                               FETCH, DECODE, ADDIEX, ADDIWB,
                               FETCH, DECODE, BEQEX,
                               FETCH, DECODE, JEX};
      logic [5:0] ops [14] = '{RT, RT, RT, RT, ADDI, ADDI, ADDI, ADDI,
                               BEQ, BEQ, BEQ, JMP, JMP, JMP};
      obs_t g;
      int rd = 0;
      int jex_ok = 0;
      for (int i = 0; i < 14; i++) begin
         cyc(0, ops[i], 1'b1, mk(seq[i], 1'b1, 1'b0), $sformatf("b2b_c%0d", i), g);
         if (g.regdst) rd++;
         if (i == 13 && g.pcsrc === 2'b10 && g.pcwrite === 1'b1) jex_ok = 1;
      end
      tests++;
      if (rd != 1) begin
         fails++;
         $display("FAIL b2b_regdst: %0d regdst cycles expected 1", rd);
      end
      tests++;
      if (jex_ok != 1) begin
         fails++;
         $display("FAIL b2b_jex: jump controls absent in cycle 13, got pcsrc %b pcwrite %b expected 10 1",
                  g.pcsrc, g.pcwrite);
      end
      tests++;
      if (st_a !== FETCH) begin
         fails++;
         $display("FAIL b2b_latency: state %0d after 14 cycles expected %0d", st_a, FETCH);
      end
   endtask

   task automatic test_illegal();
      obs_t g;
      int ill = 0;
      int bad_strobe = 0;
      cyc(0, BAD, 1'b1, mk(FETCH, 1'b1, 1'b0), "ill_fetch", g);
      if (g.illegal) ill++;
      if (g.regwrite || g.memwrite) bad_strobe++;
      cyc(0, BAD, 1'b1, mk(DECODE, 1'b1, 1'b1), "ill_decode", g);
      if (g.illegal) ill++;
      if (g.regwrite || g.memwrite || g.pcwrite) bad_strobe++;
      cyc(0, RT, 1'b0, mk(FETCH, 1'b0, 1'b0), "ill_back_to_fetch", g);
      if (g.illegal) ill++;
      tests++;
      if (ill != 1) begin
         fails++;
         $display("FAIL ill_pulse: %0d illegal cycles expected 1", ill);
      end
      tests++;
      if (bad_strobe != 0) begin
         fails++;
         $display("FAIL ill_strobes: %0d cycles with write strobes expected 0", bad_strobe);
      end
   endtask

   task automatic test_nowait();
      logic [3:0] seq [5] = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
      obs_t g;
      int irw = 0;
      rst2 = 1'b1;
      @(posedge clk);
      #1;
      rst2 = 1'b0;
      for (int n = 0; n < 2; n++) begin
         for (int i = 0; i < 5; i++) begin
            cyc(1, LW, 1'b0, mk(seq[i], 1'b1, 1'b0), $sformatf("nowait_lw%0d_c%0d", n, i), g);
            if (g.irwrite) irw++;
         end
      end
      tests++;
      if (irw != 2) begin
         fails++;
         $display("FAIL nowait_irwrite: %0d irwrite cycles expected 2", irw);
      end
      tests++;
      if (st_b !== FETCH) begin
         fails++;
         $display("FAIL nowait_latency: state %0d after 10 cycles expected %0d", st_b, FETCH);
      end
   endtask

   initial begin
      rst       = 1'b1;
      rst2      = 1'b1;
      op        = RT;
      op2       = RT;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_lw();
      test_sw_stall();
      test_reset_mid_stall();
      test_back_to_back();
      test_illegal();
      test_nowait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
